// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller ahead of a combinational 16-bit ALU.
// Owns the register file and PSR; retires one instruction every 3 cycles.
module alu_exec_ctrl #(
  parameter int NREG  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       opcode,
  input  logic [3:0]       rdest,
  input  logic [3:0]       rsrc,
  input  logic [7:0]       imm,
  input  logic             imm_sel,
  input  logic             imm_signed,
  input  logic             wr_en,
  input  logic             psr_en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [7:0]       alu_opcode,
  output logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_carry,
  input  logic             alu_flag,
  input  logic             alu_low,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic [4:0]       psr,
  output logic             done,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [3:0] rdest;
    logic [3:0] rsrc;
    logic [7:0] imm;
    logic       imm_sel;
    logic       imm_signed;
    logic       wr_en;
    logic       psr_en;
  } cap_t;

  state_t           state;
  state_t           nxt;
  cap_t             cap_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       flags_q;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] imm_ext;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt         = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) nxt = EXEC;
      end
      EXEC: nxt = WB;
      WB: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q <= '0;
    end else if (state == IDLE && instr_valid) begin
      cap_q <= '{opcode, rdest, rsrc, imm, imm_sel,
                 imm_signed, wr_en, psr_en};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (state == EXEC) begin
      result_q <= alu_c;
      flags_q  <= {alu_carry, alu_flag, alu_low,
                   alu_negative, alu_zero};
    end
  end

  // Write-back commits before the next EXEC, so no forwarding path.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      psr <= '0;
    end else if (state == WB) begin
      if (cap_q.wr_en)  regs[cap_q.rdest] <= result_q;
      if (cap_q.psr_en) psr <= flags_q;
    end
  end

  assign imm_ext = cap_q.imm_signed
    ? {{(WIDTH-8){cap_q.imm[7]}}, cap_q.imm}
    : {{(WIDTH-8){1'b0}}, cap_q.imm};

  assign alu_a        = regs[cap_q.rdest];
  assign alu_b        = cap_q.imm_sel ? imm_ext
                                      : regs[cap_q.rsrc];
  assign alu_opcode   = cap_q.opcode;
  assign alu_carry_in = psr[4];
  assign dbg_data     = regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl; the bench plays the ALU
// and keeps a register/PSR model with a retirement scoreboard.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  opcode = '0;
  logic [3:0]  rdest = '0;
  logic [3:0]  rsrc = '0;
  logic [7:0]  imm = '0;
  logic        imm_sel = 1'b0;
  logic        imm_signed = 1'b0;
  logic        wr_en = 1'b0;
  logic        psr_en = 1'b0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic [15:0] alu_c;
  logic        alu_carry;
  logic        alu_flag;
  logic        alu_low;
  logic        alu_negative;
  logic        alu_zero;
  logic [4:0]  psr;
  logic        done;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [4:0]  fl_drv = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_regs [16];
  logic [4:0]  m_psr;

  always #5 clk = ~clk;

  // Bench ALU: opcode 0 adds, anything else subtracts.
  assign alu_c = (alu_opcode == 8'h00) ? alu_a + alu_b
                                       : alu_a - alu_b;
  assign {alu_carry, alu_flag, alu_low,
          alu_negative, alu_zero} = fl_drv;

  alu_exec_ctrl dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .rdest(rdest), .rsrc(rsrc), .imm(imm),
    .imm_sel(imm_sel), .imm_signed(imm_signed),
    .wr_en(wr_en), .psr_en(psr_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .alu_c(alu_c),
    .alu_carry(alu_carry), .alu_flag(alu_flag),
    .alu_low(alu_low), .alu_negative(alu_negative),
    .alu_zero(alu_zero), .psr(psr), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_psr = '0;
  endtask

  task automatic issue(input logic [7:0] op,
                       input logic [3:0] rd,
                       input logic [3:0] rs,
                       input logic [7:0] im,
                       input logic isel, isgn, wr, pe,
                       input logic [4:0] fl);
    logic [15:0] a, b, res;
    logic        cin;
    exp_t        e;
    int          n;
    a   = m_regs[rd];
    b   = isel ? (isgn ? {{8{im[7]}}, im} : {8'h00, im})
               : m_regs[rs];
    cin = m_psr[4];
    res = (op == 8'h00) ? a + b : a - b;
    if (wr) m_regs[rd] = res;
    if (pe) m_psr = fl;
    e.rd = rd; e.val = m_regs[rd]; e.psr = m_psr;
    opcode = op; rdest = rd; rsrc = rs; imm = im;
    imm_sel = isel; imm_signed = isgn;
    wr_en = wr; psr_en = pe; fl_drv = fl;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    sb.push_back(e);
    // Junk fields held valid while busy must be ignored.
    opcode = 8'hEE; rdest = ~rd; rsrc = ~rs; imm = ~im;
    imm_sel = ~isel; wr_en = 1'b1; psr_en = 1'b1;
    chk("exec_ready", {15'd0, instr_ready}, 16'd0);
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, b);
    chk("exec_op", {8'd0, alu_opcode}, {8'd0, op});
    chk("exec_cin", {15'd0, alu_carry_in}, {15'd0, cin});
    n = 0;
    while (!done && n < 4) begin
      @(posedge clk); #1; n++;
    end
    chk("done_seen", {15'd0, done}, 16'd1);
    chk("done_latency", n[15:0], 16'd1);
    if (done) e = sb.pop_front();
    else sb.delete();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("done_pulse", {15'd0, done}, 16'd0);
    chk("idle_ready", {15'd0, instr_ready}, 16'd1);
    dbg_addr = e.rd; #1;
    chk("wb_reg", dbg_data, e.val);
    chk("wb_psr", {11'd0, psr}, {11'd0, e.psr});
  endtask

  initial begin
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      chk("reset_reg", dbg_data, 16'h0000);
    end
    chk("reset_psr", {11'd0, psr}, 16'd0);
    chk("reset_ready", {15'd0, instr_ready}, 16'd1);
    chk("reset_done", {15'd0, done}, 16'd0);

    // ADDI r1, 5
    issue(8'h00, 4'd1, 4'd0, 8'h05, 1, 0, 1, 0, 5'b00000);
    // Sign- and zero-extension of 0xFF
    issue(8'h00, 4'd6, 4'd0, 8'hFF, 1, 1, 1, 0, 5'b00000);
    issue(8'h00, 4'd7, 4'd0, 8'hFF, 1, 0, 1, 0, 5'b00000);
    // Carry out into PSR, then carry-in on the next op
    issue(8'h00, 4'd8, 4'd7, 8'h00, 0, 0, 1, 1, 5'b10000);
    issue(8'h00, 4'd9, 4'd1, 8'h00, 0, 0, 1, 0, 5'b00000);
    // CMP r2, r3: no write, PSR updated
    issue(8'h00, 4'd2, 4'd0, 8'h03, 1, 0, 1, 0, 5'b00000);
    issue(8'h00, 4'd3, 4'd0, 8'h07, 1, 0, 1, 0, 5'b00000);
    issue(8'h01, 4'd2, 4'd3, 8'h00, 0, 0, 0, 1, 5'b00110);
    chk("cmp_psr", {11'd0, psr}, 16'h0006);
    // rdest == rsrc reads the same pre-write value
    issue(8'h00, 4'd3, 4'd3, 8'h00, 0, 0, 1, 0, 5'b00000);
    // Dependent pair: r1 += r2, then r5 += r1
    issue(8'h00, 4'd1, 4'd2, 8'h00, 0, 0, 1, 0, 5'b00000);
    issue(8'h00, 4'd5, 4'd1, 8'h00, 0, 0, 1, 0, 5'b00000);
    chk("dep_r5", dbg_data, 16'h0008);

    // Reset during EXEC of a write to r4 aborts it
    opcode = 8'h00; rdest = 4'd4; rsrc = 4'd0; imm = 8'h2A;
    imm_sel = 1; imm_signed = 0; wr_en = 1; psr_en = 1;
    fl_drv = 5'b11111; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("abort_exec_b", alu_b, 16'h002A);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    dbg_addr = 4'd4; #1;
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_ready", {15'd0, instr_ready}, 16'd1);
    chk("abort_r4", dbg_data, 16'h0000);
    chk("abort_psr", {11'd0, psr}, 16'd0);
    @(posedge clk); #1;
    chk("abort_no_done", {15'd0, done}, 16'd0);
    dbg_addr = 4'd1; #1;
    chk("abort_r1", dbg_data, 16'h0000);
    // Normal operation resumes after the abort
    issue(8'h00, 4'd4, 4'd0, 8'h80, 1, 1, 1, 1, 5'b00001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller directly upstream of the 16-bit ALU.
- Accepts one decoded instruction per handshake and owns a 16x16 register file and a 5-bit processor status register (PSR).
- Drives the ALU operands, opcode and carry-in, captures the ALU result and flags, and writes results back.
- Sits between the instruction decoder and the ALU; the ALU stays purely combinational.

Parameters:
- NREG, 16, number of general registers; index width is 4 bits, fixed.
- WIDTH, 16, data width; must match the ALU.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  decoder presents an instruction
- instr_ready  out  1  controller can accept an instruction
- opcode  in  8  ALU opcode, passed through unchanged
- rdest  in  4  destination register index; also the A operand source
- rsrc  in  4  source register index for the B operand
- imm  in  8  immediate value
- imm_sel  in  1  1: B is the extended imm; 0: B is reg[rsrc]
- imm_signed  in  1  1: sign-extend imm; 0: zero-extend imm
- wr_en  in  1  write the ALU result to reg[rdest] (0 for CMP/CMPI/NOP)
- psr_en  in  1  update the PSR from the ALU flags
- alu_a  out  16  ALU A operand
- alu_b  out  16  ALU B operand
- alu_opcode  out  8  ALU opcode
- alu_carry_in  out  1  ALU CarryIn
- alu_c  in  16  ALU result
- alu_carry, alu_flag, alu_low, alu_negative, alu_zero  in  1 each  ALU flags
- psr  out  5  {Carry, Flag, Low, Negative, Zero}
- done  out  1  one-cycle pulse marking instruction retirement
- dbg_addr  in  4  debug read index
- dbg_data  out  16  reg[dbg_addr], combinational read of committed state

Behaviour:
- Reset:
  - Synchronous; state=IDLE.
  - All registers and the PSR cleared to 0.
  - Captured fields cleared; done=0; instr_ready=1 in the cycle after reset.
  - Reset in any state aborts the instruction in flight: no register write, no PSR update, no done.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On an edge with instr_valid=1, capture opcode, rdest, rsrc, imm, imm_sel, imm_signed, wr_en and psr_en; go to EXEC.
  - With instr_valid=0, stay in IDLE.
- EXEC:
  - instr_ready=0.
  - alu_a = reg[rdest_q].
  - alu_b = imm_sel_q ? ext(imm_q) : reg[rsrc_q].
  - ext: sign-extend imm_q[7] when imm_signed_q=1, otherwise zero-extend.
  - alu_opcode = opcode_q; alu_carry_in = psr[4].
  - On the edge, latch alu_c into result_q and the five ALU flags into flags_q; go to WB.
- WB:
  - instr_ready=0; done=1 (Moore output, exactly one cycle).
  - On the edge: if wr_en_q, reg[rdest_q] <= result_q; if psr_en_q, psr <= flags_q; go to IDLE.
- Outside EXEC, alu_a, alu_b and alu_opcode hold their last captured-field values; alu_carry_in always equals psr[4].
- Throughput: one instruction per 3 cycles. Accept edge N, write and PSR visible after edge N+2, done high in the cycle between edges N+1 and N+2.
- Back-to-back dependent instructions need no forwarding: the write commits before the next EXEC reads.
- rdest==rsrc is legal; both operands read the same pre-write value.
- A wr_en=0 instruction leaves the register file untouched, but the PSR still updates if psr_en=1.
- dbg_data reflects a write starting the cycle after the WB edge.
- instr_valid while not in IDLE is ignored; fields are not captured.

Test Plan:
- Reset, then dbg read of every register -> all 0x0000; psr=0; instr_ready=1.
- ADDI-style: rdest=1, imm=0x05, imm_sel=1, imm_signed=0, wr_en=1 with reg1=0 -> alu_a=0x0000, alu_b=0x0005 in EXEC; reg1=0x0005 after WB; done pulses once; accept-to-IDLE takes 3 cycles.
- Sign extension: imm=0xFF, imm_signed=1 -> alu_b=0xFFFF; imm_signed=0 -> alu_b=0x00FF.
- Carry chain: ALU model returns alu_carry=1 with psr_en=1 -> psr[4]=1 after WB; next instruction sees alu_carry_in=1 during EXEC.
- Compare: wr_en=0, psr_en=1, reg2=0x0003, reg3=0x0007 with ALU Low=1, Negative=1 -> reg2 unchanged at 0x0003; psr=5'b00110.
- Reset asserted during EXEC of a write to reg4 -> reg4 stays 0, no done, state IDLE next cycle.
- Dependent pair: r1+=r2 then r5+=r1 issued back to back -> second EXEC alu_b equals the new r1.
